// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
//
// Input-side controller for the MM:SS clock. Debounces the four active-low
// push buttons, turns presses into digit edits on a local BCD buffer and
// drives the preset-load port of the digit-counter chain. While editing the
// counters are held frozen at the buffer contents; on exit the load strobe
// drops and the counters run on from the edited value.
//
// Ports:
//   CLK           system clock
//   RESET_N       asynchronous, active-low reset
//   KEY[3:0]      raw buttons, active-low: [0] enter/exit edit, [1] next
//                 digit, [2] increment digit (auto-repeats), [3] clear buffer
//   CUR_DIGITS    live BCD time {min_hi, min_lo, sec_hi, sec_lo}
//   WRITE_ENABLE  load strobe to the digit counters (high throughout edit)
//   WRITE_VALUE   BCD preset, same packing as CUR_DIGITS
//   EDIT_MODE     high while editing
//   BLINK         one-hot selected digit while editing ([3] = min_hi), else 0
// ---------------------------------------------------------------------------
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_BITS        = 25
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  KEY,
  input  logic [15:0] CUR_DIGITS,
  output logic        WRITE_ENABLE,
  output logic [15:0] WRITE_VALUE,
  output logic        EDIT_MODE,
  output logic [3:0]  BLINK
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  localparam logic [CNT_BITS-1:0] DB_LAST    = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] REP_DELAY  = CNT_BITS'(REPEAT_DELAY);
  // After a tick the counter restarts so the next tick lands REPEAT_RATE
  // cycles later on the same REP_DELAY compare value.
  localparam logic [CNT_BITS-1:0] REP_RELOAD = CNT_BITS'(REPEAT_DELAY - REPEAT_RATE + 1);

  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          stable_q, stable_d;
  logic [3:0]          stable_dly_q;
  logic [3:0]          press_q, press_d;
  logic [CNT_BITS-1:0] db_cnt_q [4];
  logic [CNT_BITS-1:0] db_cnt_d [4];

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [15:0]         edit_buf_q, edit_buf_d;
  logic [CNT_BITS-1:0] rep_cnt_q, rep_cnt_d;
  logic                we_q, we_d;
  logic                edit_q, edit_d;
  logic [3:0]          blink_q, blink_d;

  logic                ev0, ev1, ev2, ev3;
  logic                rep_tick;
  logic [3:0]          cur_digit;
  logic [3:0]          digit_limit;

  // Digit increment with wrap: anything at or above the limit (including
  // out-of-range captured values) returns to zero.
  function automatic logic [3:0] inc_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  // Debounce: the counter runs only while the synced level disagrees with
  // the accepted level, and a disagreement lasting DEBOUNCE_CYCLES wins.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Press pulse is the registered 1->0 transition of the accepted level.
  assign press_d = stable_dly_q & ~stable_q;

  // Fixed event priority KEY[0] > KEY[3] > KEY[1] > KEY[2].
  assign ev0 = press_q[0];
  assign ev3 = press_q[3] & ~press_q[0];
  assign ev1 = press_q[1] & ~press_q[0] & ~press_q[3];
  assign ev2 = press_q[2] & ~press_q[0] & ~press_q[3] & ~press_q[1];

  assign cur_digit   = edit_buf_q[{sel_q, 2'b00} +: 4];
  assign digit_limit = sel_q[0] ? 4'd5 : 4'd9;

  // Auto-repeat counter: armed to 1 by a winning KEY[2] press, advanced
  // while the key stays accepted-low in edit, and dropped to 0 (inactive)
  // by release, exit or any higher-priority event.
  always_comb begin
    rep_cnt_d = '0;
    rep_tick  = 1'b0;
    if (state_q == ST_EDIT && !press_q[0]) begin
      if (ev2) begin
        rep_cnt_d = CNT_BITS'(1);
      end else if (press_q[3] || press_q[1]) begin
        rep_cnt_d = '0;
      end else if (rep_cnt_q != '0 && !stable_q[2]) begin
        if (rep_cnt_q == REP_DELAY) begin
          rep_tick  = 1'b1;
          rep_cnt_d = REP_RELOAD;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end
  end

  // Mode FSM and buffer editing; outputs are precomputed from next state so
  // they come straight from flops.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    edit_buf_d = edit_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (ev0) begin
          state_d    = ST_EDIT;
          edit_buf_d = CUR_DIGITS;
          sel_d      = 2'd3;
        end
      end
      ST_EDIT: begin
        if (ev0) begin
          state_d = ST_IDLE;
        end else if (ev3) begin
          edit_buf_d = 16'h0000;
        end else if (ev1) begin
          sel_d = sel_q - 2'd1;
        end else if (ev2 || rep_tick) begin
          edit_buf_d[{sel_q, 2'b00} +: 4] = inc_digit(cur_digit, digit_limit);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    we_d    = (state_d == ST_EDIT);
    edit_d  = (state_d == ST_EDIT);
    blink_d = (state_d == ST_EDIT) ? (4'b0001 << sel_d) : 4'b0000;
  end

  // All state registers; keys reset to the released level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q      <= 4'hF;
      sync2_q      <= 4'hF;
      stable_q     <= 4'hF;
      stable_dly_q <= 4'hF;
      press_q      <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      state_q      <= ST_IDLE;
      sel_q        <= 2'd3;
      edit_buf_q   <= 16'h0000;
      rep_cnt_q    <= '0;
      we_q         <= 1'b0;
      edit_q       <= 1'b0;
      blink_q      <= 4'h0;
    end else begin
      sync1_q      <= KEY;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q      <= state_d;
      sel_q        <= sel_d;
      edit_buf_q   <= edit_buf_d;
      rep_cnt_q    <= rep_cnt_d;
      we_q         <= we_d;
      edit_q       <= edit_d;
      blink_q      <= blink_d;
    end
  end

  assign WRITE_ENABLE = we_q;
  assign WRITE_VALUE  = edit_buf_q;
  assign EDIT_MODE    = edit_q;
  assign BLINK        = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// ---------------------------------------------------------------------------
// tb_time_set_controller
//
// Drives button actions (one key pattern held for a number of cycles, then
// released and allowed to settle) and compares the outputs against an
// action-level model: a held pattern either is a glitch (no event) or yields
// one prioritised event plus a computed number of auto-repeat ticks.
// ---------------------------------------------------------------------------
module tb_time_set_controller;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  KEY;
  logic [15:0] CUR_DIGITS;
  logic        WRITE_ENABLE;
  logic [15:0] WRITE_VALUE;
  logic        EDIT_MODE;
  logic [3:0]  BLINK;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state.
  bit mEdit;
  int mDig [4];
  int mSel;

  time_set_controller #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .CNT_BITS(8)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .KEY(KEY),
    .CUR_DIGITS(CUR_DIGITS),
    .WRITE_ENABLE(WRITE_ENABLE),
    .WRITE_VALUE(WRITE_VALUE),
    .EDIT_MODE(EDIT_MODE),
    .BLINK(BLINK)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] modelValue();
    return 16'((mDig[3] << 12) | (mDig[2] << 8) | (mDig[1] << 4) | mDig[0]);
  endfunction

  function automatic int incDigit(input int d, input int idx);
    int lim;
    lim = (idx == 3 || idx == 1) ? 5 : 9;
    return (d >= lim) ? 0 : d + 1;
  endfunction

  task automatic checkAll(input string where);
    checkOutput({where, ".we"},    16'(WRITE_ENABLE), 16'(mEdit));
    checkOutput({where, ".edit"},  16'(EDIT_MODE),    16'(mEdit));
    checkOutput({where, ".value"}, WRITE_VALUE,       modelValue());
    checkOutput({where, ".blink"}, 16'(BLINK),        mEdit ? 16'(1 << mSel) : 16'h0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Effect of one held action on the model. A hold of at least D cycles is
  // accepted; a winning KEY[2] keeps ticking RR apart starting RD cycles
  // after the press until the release is accepted, which allows ticks while
  // hold-2 >= RD.
  task automatic modelAction(input logic [3:0] mask, input int hold, input logic [15:0] cur);
    int ticks;
    if (hold < D) return;
    if (mask[0]) begin
      if (!mEdit) begin
        for (int i = 0; i < 4; i++) mDig[i] = (cur >> (4 * i)) & 15;
        mSel = 3;
      end
      mEdit = !mEdit;
    end else if (!mEdit) begin
      return;
    end else if (mask[3]) begin
      for (int i = 0; i < 4; i++) mDig[i] = 0;
    end else if (mask[1]) begin
      mSel = (mSel + 3) % 4;
    end else if (mask[2]) begin
      ticks = (hold - 2 >= RD) ? (hold - 2 - RD) / RR + 1 : 0;
      for (int k = 0; k <= ticks; k++) mDig[mSel] = incDigit(mDig[mSel], mSel);
    end
  endtask

  // Hold the keys in mask low for hold cycles, release, let it settle.
  task automatic applyStimulus(input logic [3:0] mask, input int hold);
    KEY = ~mask;
    waitCycles(hold);
    KEY = 4'hF;
    waitCycles(D + 8);
    modelAction(mask, hold, CUR_DIGITS);
  endtask

  initial begin
    logic [3:0] mask;
    int hold;
    int pick;

    mEdit = 0;
    mSel  = 3;
    for (int i = 0; i < 4; i++) mDig[i] = 0;

    RESET_N    = 1'b0;
    KEY        = 4'hF;
    CUR_DIGITS = 16'h1234;
    #22;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    waitCycles(50);
    checkAll("reset");

    // A 3-cycle glitch on KEY[0] must not enter edit.
    applyStimulus(4'b0001, 3);
    checkAll("glitch");

    // Entry latency: outputs change on the 8th edge after the key goes low.
    KEY = 4'hE;
    waitCycles(7);
    checkOutput("lat7.edit", 16'(EDIT_MODE), 16'h0);
    waitCycles(1);
    checkOutput("lat8.edit",  16'(EDIT_MODE), 16'h1);
    checkOutput("lat8.value", WRITE_VALUE,    16'h1234);
    checkOutput("lat8.blink", 16'(BLINK),     16'h8);
    waitCycles(2);
    KEY = 4'hF;
    waitCycles(D + 8);
    modelAction(4'b0001, 10, 16'h1234);
    checkAll("enter");

    repeat (3) applyStimulus(4'b0100, 6);
    checkOutput("inc3", WRITE_VALUE, 16'h4234);
    repeat (2) applyStimulus(4'b0100, 6);
    checkOutput("wrap5", WRITE_VALUE, 16'h0234);
    applyStimulus(4'b0010, 6);
    checkOutput("next.blink", 16'(BLINK), 16'h4);
    repeat (8) applyStimulus(4'b0100, 6);
    checkOutput("wrap9", WRITE_VALUE, 16'h0034);
    checkAll("digits");

    // Auto-repeat on digit 0 from zero: press + 4 ticks.
    applyStimulus(4'b1000, 6);
    applyStimulus(4'b0010, 6);
    applyStimulus(4'b0010, 6);
    applyStimulus(4'b0100, 39);
    checkOutput("repeat", WRITE_VALUE, 16'h0005);
    checkAll("repeat");

    // KEY[3] beats KEY[2]; no increments, even with a long hold.
    applyStimulus(4'b1100, 30);
    checkOutput("clrpri", WRITE_VALUE, 16'h0000);
    applyStimulus(4'b0001, 6);
    checkOutput("exit.we", 16'(WRITE_ENABLE), 16'h0);
    checkAll("exit");

    // Randomised actions.
    for (int n = 0; n < 80; n++) begin
      CUR_DIGITS = 16'($urandom);
      pick = $urandom_range(0, 9);
      if (pick < 3)      mask = 4'b0001;
      else if (pick < 6) mask = 4'b0100;
      else               mask = 4'($urandom_range(1, 15));
      pick = $urandom_range(0, 9);
      if (pick < 2)      hold = $urandom_range(1, D - 1);
      else if (pick < 6) hold = $urandom_range(D, 12);
      else               hold = $urandom_range(18, 45);
      applyStimulus(mask, hold);
      checkAll($sformatf("rand%0d", n));
    end

    // Asynchronous reset in the middle of an edit.
    if (mEdit) applyStimulus(4'b0001, 6);
    CUR_DIGITS = 16'h5900;
    applyStimulus(4'b0001, 6);
    checkAll("pre_rst");
    #2;
    RESET_N = 1'b0;
    #1;
    mEdit = 0;
    mSel  = 3;
    for (int i = 0; i < 4; i++) mDig[i] = 0;
    checkAll("async_rst");
    #20;
    RESET_N = 1'b1;
    waitCycles(5);
    checkAll("post_rst");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
